// File: rtl/config_flop_pkg.sv
// Shared constants and types for the configurable flop bank: mode encoding
// and the layout of each channel's 4-bit configuration field.
package config_flop_pkg;

    localparam int CFG_BITS  = 4;
    localparam int MODE_LSB  = 0;
    localparam int INIT_BIT  = 2;
    localparam int INV_BIT   = 3;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_DFF    = 2'b01,
        MODE_TFF    = 2'b10,
        MODE_DFF2   = 2'b11
    } mode_e;

    // Packed so that bit 3 = INV, bit 2 = INIT, bits 1:0 = mode.
    typedef struct packed {
        logic  inv;
        logic  init;
        mode_e mode;
    } cell_cfg_t;

endpackage

// File: rtl/config_flop_bank_if.sv
// Control/data bundle of the flop bank plus a view of the active configuration.
interface config_flop_bank_if #(
    parameter int WIDTH = 8
);
    import config_flop_pkg::*;

    // No handshake: every control and d is sampled on each rising clock edge,
    // q and shift_o are continuously valid outputs.
    logic                      shift_en;
    logic                      shift_i;
    logic                      shift_o;
    logic                      cfg_load;
    logic                      set;
    logic                      ce;
    logic [WIDTH-1:0]          d;
    logic [WIDTH-1:0]          q;
    logic [WIDTH*CFG_BITS-1:0] active_cfg;

    modport master (
        output shift_en, shift_i, cfg_load, set, ce, d,
        input  shift_o, q, active_cfg
    );

    modport slave (
        input  shift_en, shift_i, cfg_load, set, ce, d,
        output shift_o, q, active_cfg
    );

endinterface

// File: rtl/flop_cell.sv
// One storage channel: active config register, two data stages and the
// mode/inversion output mux.
module flop_cell
    import config_flop_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                hold_i,
    input  logic                set_i,
    input  logic                ce_i,
    input  logic                d_i,
    input  logic [CFG_BITS-1:0] cfg_i,
    output logic                q_o,
    output cell_cfg_t           cfg_o
);

    cell_cfg_t cfg_q, cfg_d;
    cell_cfg_t new_cfg;
    logic      s1_q, s1_d;
    logic      s2_q, s2_d;

    assign new_cfg = cell_cfg_t'(cfg_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q <= '0;
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
        end
    end

    // load_i already excludes shifting, so it outranks the shift freeze.
    always_comb begin
        cfg_d = cfg_q;
        s1_d  = s1_q;
        s2_d  = s2_q;
        if (load_i) begin
            cfg_d = new_cfg;
            s1_d  = new_cfg.init;
            s2_d  = new_cfg.init;
        end else if (!hold_i) begin
            if (set_i) begin
                s1_d = cfg_q.init;
                s2_d = cfg_q.init;
            end else if (ce_i) begin
                s2_d = s1_q;
                case (cfg_q.mode)
                    MODE_TFF: s1_d = s1_q ^ d_i;
                    default:  s1_d = d_i;
                endcase
            end
        end
    end

    always_comb begin
        q_o = s1_q ^ cfg_q.inv;
        case (cfg_q.mode)
            MODE_BYPASS: q_o = d_i ^ cfg_q.inv;
            MODE_DFF2:   q_o = s2_q ^ cfg_q.inv;
            default:     q_o = s1_q ^ cfg_q.inv;
        endcase
    end

    assign cfg_o = cfg_q;

endmodule

// File: rtl/config_flop_bank.sv
// Bank of WIDTH configurable flop channels sharing one serial shadow
// configuration chain that can be daisy-chained through shift_o.
module config_flop_bank #(
    parameter int WIDTH    = 8,
    parameter int CFG_BITS = 4
) (
    input  logic               flop_clk,
    input  logic               rst,
    config_flop_bank_if.slave  bus
);
    import config_flop_pkg::*;

    localparam int CHAIN_W = WIDTH * CFG_BITS;

    logic [CHAIN_W-1:0] chain_q, chain_d;
    logic [WIDTH-1:0]   q_w;
    logic [CHAIN_W-1:0] cfg_w;
    logic               load;

    // New bits enter at the top so the first bit shifted in ends at bit 0.
    always_comb begin
        chain_d = chain_q;
        if (bus.shift_en) begin
            chain_d = {bus.shift_i, chain_q[CHAIN_W-1:1]};
        end
    end

    always_ff @(posedge flop_clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign load = bus.cfg_load & ~bus.shift_en;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        flop_cell u_cell (
            .clk_i  (flop_clk),
            .rst_i  (rst),
            .load_i (load),
            .hold_i (bus.shift_en),
            .set_i  (bus.set),
            .ce_i   (bus.ce),
            .d_i    (bus.d[gi]),
            .cfg_i  (chain_q[gi*CFG_BITS +: CFG_BITS]),
            .q_o    (q_w[gi]),
            .cfg_o  (cfg_w[gi*CFG_BITS +: CFG_BITS])
        );
    end

    assign bus.shift_o    = chain_q[0];
    assign bus.q          = q_w;
    assign bus.active_cfg = cfg_w;

endmodule

// File: doc/config_flop_bank.md
CONFIG_FLOP_BANK -- requirements
Module: config_flop_bank

Interface
REQ-001 Parameter: WIDTH, default 8, number of independent storage channels (1..64).
REQ-002 Parameter: CFG_BITS, default 4, configuration bits per channel; fixed at 4.
REQ-003 Port: flop_clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: shift_en  input  1  shifts config chain one bit per cycle.
REQ-006 Port: shift_i  input  1  config chain serial input.
REQ-007 Port: shift_o  output  1  config chain serial output, for daisy-chaining.
REQ-008 Port: cfg_load  input  1  copies shadow chain into active config.
REQ-009 Port: set  input  1  synchronous preset of all channels to their INIT bit.
REQ-010 Port: ce  input  1  clock enable for data capture.
REQ-011 Port: d  input  WIDTH  per-channel data in.
REQ-012 Port: q  output  WIDTH  per-channel data out.

Function
REQ-013 Shadow chain SHALL be WIDTH*4 bits; when shift_en=1: chain <= {shift_i, chain[top:1]}; shift_o SHALL equal chain[0] combinationally.
REQ-014 After WIDTH*4 shifts, the first bit shifted in SHALL sit at chain[0]; channel i config = chain[4i+3:4i].
REQ-015 Config fields per channel: [1:0] mode (00 BYPASS, 01 DFF, 10 TFF, 11 DFF2), [2] INIT, [3] INV.
REQ-016 cfg_load=1 with shift_en=0 SHALL copy the shadow chain to active config on the edge and load every stage register of every channel with the new INIT bit.
REQ-017 cfg_load=1 with shift_en=1 SHALL be ignored (no active-config change).
REQ-018 While shift_en=1, all data stage registers SHALL hold (no capture, no set); active config unchanged.
REQ-019 Data priority per edge: rst (async) > cfg_load > set > ce capture > hold.
REQ-020 set=1 SHALL load both stage registers of each channel with its active INIT bit.
REQ-021 DFF: on ce=1, stage1 <= d[i]; q[i] = stage1 ^ INV; latency 1 cycle.
REQ-022 TFF: on ce=1, stage1 <= stage1 ^ d[i]; q[i] = stage1 ^ INV.
REQ-023 DFF2: on ce=1, stage1 <= d[i], stage2 <= stage1; q[i] = stage2 ^ INV; latency 2 enabled cycles.
REQ-024 BYPASS: q[i] = d[i] ^ INV combinationally; stage registers still track as DFF but are unused.
REQ-025 Channels SHALL be fully independent; no cross-channel interaction except shared chain and controls.

Reset
REQ-026 rst=1 SHALL asynchronously clear shadow chain, active config and all stage registers to 0.
REQ-027 After reset all channels are BYPASS, INV=0: q SHALL equal d; shift_o SHALL be 0.
REQ-028 rst asserted mid-shift SHALL discard the partial configuration; no cfg_load is implied.

Structure
REQ-029 Package config_flop_pkg SHALL hold CFG_BITS, mode encodings (enum) and config field offsets.
REQ-030 One sub-module flop_cell SHALL implement a single channel (stages, mode mux, INV); the top instantiates WIDTH copies plus the chain.

Verification
REQ-031 Reset: WIDTH=8, rst pulse, d=8'hA5 -> q=8'hA5, shift_o=0.
REQ-032 Shift/readback: shift 32 bits pattern 0x1234_5678 LSB first, then 32 more zeros -> shift_o reproduces pattern LSB first on shifts 33..64 in order.
REQ-033 DFF2 latency: all channels mode=11, INIT=0, cfg_load, ce=1, d=8'hFF for one cycle then 0 -> q=8'hFF exactly 2 cycles after d applied, for one cycle.
REQ-034 TFF + INV: ch0 mode=10, INV=1, INIT=0; cfg_load -> q[0]=1; d[0]=1, ce=1 for 3 cycles -> q[0] = 0,1,0.
REQ-035 Freeze/set: DFF mode, INIT=1, load 8'h00 via ce; shift_en=1 with ce=1, d=8'hFF -> q stays 8'h00; then set=1 -> q=8'hFF.
REQ-036 Simultaneous: cfg_load with shift_en=1 -> active config unchanged; rst mid-shift after 13 bits -> chain all zero, q=d.
